strobe_ctrl: RTL and testbench

STROBE_CTRL -- requirements
Module: strobe_ctrl

---
 rtl/strobe_ctrl_pkg.sv | 13 +
 rtl/strobe_ctrl_cnt.sv | 27 ++
 rtl/strobe_ctrl.sv | 147 ++++++++++++++
 tb/tb_strobe_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strobe_ctrl_pkg.sv
// rtl/strobe_ctrl_pkg.sv - shared types and constants for the strobe controller
package strobe_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DELAY    = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_STOPPING = 2'd3
    } strobe_ctrl_state_t;

endpackage

// File: rtl/strobe_ctrl_cnt.sv
// rtl/strobe_ctrl_cnt.sv - loadable down-counter with zero flag
module strobe_ctrl_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // Load wins over decrement; the caller only decrements a nonzero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/strobe_ctrl.sv
// rtl/strobe_ctrl.sv - marker-aligned strobe generator with delayed start and graceful stop
module strobe_ctrl
    import strobe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             stop_req,
    input  logic [CNT_W-1:0] interval,
    input  logic [CNT_W-1:0] delay_value,
    input  logic             user_marker,
    output logic             user_strobe,
    output logic             stop_ack,
    output logic             active,
    output logic             busy,
    output logic [CNT_W-1:0] strobe_count
);

    strobe_ctrl_state_t state;
    strobe_ctrl_state_t state_next;

    logic             armed;
    logic [CNT_W-1:0] lat_interval;
    logic [CNT_W-1:0] delay_cnt;
    logic             delay_zero;
    logic [CNT_W-1:0] int_cnt;
    logic             int_zero;
    logic             start;
    logic             run;
    logic             strobe;
    logic             ack_cond;
    logic             to_idle;

    assign start   = (state == ST_IDLE) && enable && armed && !stop_req;
    assign to_idle = (state != ST_IDLE) && (state_next == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (delay_value != '0) ? ST_DELAY : ST_ACTIVE;
                end
            end
            ST_DELAY: begin
                if (!enable || stop_req) begin
                    state_next = ST_IDLE;
                end else if (delay_zero) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (stop_req) begin
                    state_next = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (!enable || strobe) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        run      = (state == ST_ACTIVE) || (state == ST_STOPPING);
        strobe   = run && user_marker && int_zero;
        active   = run;
        busy     = (state != ST_IDLE);
        ack_cond = 1'b0;
        case (state)
            ST_IDLE:     ack_cond = stop_req;
            ST_DELAY:    ack_cond = stop_req;
            ST_ACTIVE:   ack_cond = !enable && stop_req;
            ST_STOPPING: ack_cond = !enable || strobe;
            default:     ack_cond = 1'b0;
        endcase
    end

    assign user_strobe = strobe;

    // Delay counter holds delay_value-1 so DELAY spans exactly delay_value cycles.
    strobe_ctrl_cnt #(.W(CNT_W)) u_delay_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (start),
        .load_value ((delay_value == '0) ? '0 : (delay_value - CNT_W'(1))),
        .dec        ((state == ST_DELAY) && (delay_cnt != '0)),
        .count      (delay_cnt),
        .zero       (delay_zero)
    );

    strobe_ctrl_cnt #(.W(CNT_W)) u_int_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (start || strobe),
        .load_value (start ? '0 : lat_interval),
        .dec        (run && user_marker && (int_cnt != '0)),
        .count      (int_cnt),
        .zero       (int_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_interval <= '0;
            strobe_count <= '0;
        end else if (start) begin
            lat_interval <= interval;
            strobe_count <= '0;
        end else if (strobe && (strobe_count != '1)) begin
            strobe_count <= strobe_count + CNT_W'(1);
        end
    end

    // An enable low phase re-arms; every fall back to IDLE disarms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b1;
        end else if (!enable) begin
            armed <= 1'b1;
        end else if (to_idle) begin
            armed <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_ack <= 1'b0;
        end else begin
            stop_ack <= ack_cond && !stop_ack;
        end
    end

endmodule

// File: tb/tb_strobe_ctrl.sv
// tb/tb_strobe_ctrl.sv - directed and randomized checks of strobe_ctrl against a cycle model
module tb_strobe_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;
    localparam int M_STOP = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        stop_req;
    logic        user_marker;
    logic [15:0] interval;
    logic [15:0] delay_value;

    logic        user_strobe, stop_ack, active, busy;
    logic [15:0] strobe_count;
    logic        us4, ack4, act4, busy4;
    logic [3:0]  cnt4;

    int vectors = 0;
    int errors  = 0;

    int m_mode, m_wait, m_gap, m_lat, m_cnt;
    bit m_armed, m_ack;

    bit seen_strobe, seen_busy;
    int n_strobe, n_ack, n_busy, first;

    always #5 clk = ~clk;

    strobe_ctrl #(.CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .stop_req     (stop_req),
        .interval     (interval),
        .delay_value  (delay_value),
        .user_marker  (user_marker),
        .user_strobe  (user_strobe),
        .stop_ack     (stop_ack),
        .active       (active),
        .busy         (busy),
        .strobe_count (strobe_count)
    );

    strobe_ctrl #(.CNT_W(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .stop_req     (stop_req),
        .interval     (interval[3:0]),
        .delay_value  (delay_value[3:0]),
        .user_marker  (user_marker),
        .user_strobe  (us4),
        .stop_ack     (ack4),
        .active       (act4),
        .busy         (busy4),
        .strobe_count (cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_wait  = 0;
        m_gap   = 0;
        m_lat   = 0;
        m_cnt   = 0;
        m_armed = 1'b1;
        m_ack   = 1'b0;
    endtask

    function automatic bit m_strobe();
        return (m_mode == M_RUN || m_mode == M_STOP) && user_marker && (m_gap == 0);
    endfunction

    task automatic model_advance();
        bit s    = m_strobe();
        bit left = 1'b0;
        bit ackn = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (stop_req) ackn = 1'b1;
                else if (enable && m_armed) begin
                    m_lat = int'(interval);
                    m_gap = 0;
                    m_cnt = 0;
                    if (delay_value == 0) m_mode = M_RUN;
                    else begin
                        m_mode = M_WAIT;
                        m_wait = int'(delay_value);
                    end
                end
            end
            M_WAIT: begin
                if (!enable || stop_req) begin
                    m_mode = M_IDLE;
                    left   = 1'b1;
                    ackn   = stop_req;
                end else begin
                    m_wait--;
                    if (m_wait == 0) m_mode = M_RUN;
                end
            end
            default: begin
                if (s) begin
                    m_cnt++;
                    m_gap = m_lat;
                end else if (user_marker && m_gap > 0) begin
                    m_gap--;
                end
                if (!enable) begin
                    ackn   = (m_mode == M_STOP) || stop_req;
                    left   = 1'b1;
                    m_mode = M_IDLE;
                end else if (m_mode == M_STOP && s) begin
                    ackn   = 1'b1;
                    left   = 1'b1;
                    m_mode = M_IDLE;
                end else if (m_mode == M_RUN && stop_req) begin
                    m_mode = M_STOP;
                end
            end
        endcase
        if (!enable) m_armed = 1'b1;
        else if (left) m_armed = 1'b0;
        m_ack = ackn && !m_ack;
    endtask

    // Inputs are set at the falling edge; outputs are checked 1 time unit later.
    task automatic step();
        bit run;
        #1;
        run = (m_mode == M_RUN || m_mode == M_STOP);
        chk("user_strobe", user_strobe, m_strobe());
        chk("stop_ack", stop_ack, m_ack);
        chk("active", active, run);
        chk("busy", busy, m_mode != M_IDLE);
        chk("strobe_count", strobe_count, (m_cnt > 65535) ? 65535 : m_cnt);
        chk("w4_user_strobe", us4, m_strobe());
        chk("w4_stop_ack", ack4, m_ack);
        chk("w4_busy", busy4, m_mode != M_IDLE);
        chk("w4_strobe_count", cnt4, (m_cnt > 15) ? 15 : m_cnt);
        vectors++;
        seen_strobe = user_strobe;
        seen_busy   = busy;
        n_strobe += int'(user_strobe);
        n_ack    += int'(stop_ack);
        n_busy   += int'(busy);
        if (rst_n) model_advance();
        @(negedge clk);
    endtask

    task automatic clear_tallies();
        n_strobe = 0;
        n_ack    = 0;
        n_busy   = 0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; stop_req = 1'b0; user_marker = 1'b0;
        interval = '0; delay_value = '0;
        model_reset();
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();

        // Delay of 3 with back-to-back markers: busy next cycle, first strobe at T+4.
        delay_value = 16'd3; interval = 16'd0; user_marker = 1'b1; enable = 1'b1;
        step();
        first = 0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 1) chk("req032_busy_t1", seen_busy, 1'b1);
            if (seen_strobe && first == 0) first = i;
        end
        chk("req032_first_strobe", first, 4);
        enable = 1'b0; user_marker = 1'b0;
        step(); step();

        // Interval 2: strobes on markers 1, 4, 7.
        delay_value = 16'd0; interval = 16'd2; enable = 1'b1;
        step();
        user_marker = 1'b1;
        clear_tallies();
        for (int i = 0; i < 7; i++) step();
        chk("req033_count", strobe_count, 16'd3);
        chk("req033_strobes", n_strobe, 3);
        enable = 1'b0; user_marker = 1'b0;
        step(); step();

        // Graceful stop with two markers still to skip.
        enable = 1'b1;
        step();
        user_marker = 1'b1;
        step();
        user_marker = 1'b0; stop_req = 1'b1;
        clear_tallies();
        step();
        stop_req = 1'b0; user_marker = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("req034_one_strobe", n_strobe, 1);
        chk("req034_one_ack", n_ack, 1);
        clear_tallies();
        for (int i = 0; i < 5; i++) step();
        chk("req034_no_restart", n_busy, 0);
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        step();
        chk("req034_restart", seen_busy, 1'b1);
        enable = 1'b0; user_marker = 1'b0;
        step(); step();

        // Abort mid-delay, then abort together with a stop request.
        delay_value = 16'd10; interval = 16'd0; user_marker = 1'b1; enable = 1'b1;
        clear_tallies();
        step();
        for (int i = 0; i < 5; i++) step();
        enable = 1'b0;
        step();
        step();
        chk("req035_idle", seen_busy, 1'b0);
        step(); step();
        chk("req035_no_strobe", n_strobe, 0);
        chk("req035_no_ack", n_ack, 0);
        enable = 1'b1;
        step();
        for (int i = 0; i < 3; i++) step();
        enable = 1'b0; stop_req = 1'b1;
        clear_tallies();
        step();
        stop_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("req035_single_ack", n_ack, 1);

        // Saturation of the 4-bit instance, then reset while running.
        delay_value = 16'd0; interval = 16'd0; user_marker = 1'b0; enable = 1'b1;
        step();
        user_marker = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("req036_sat4", cnt4, 4'd15);
        chk("req036_count16", strobe_count, 16'd20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_strobe", {user_strobe, us4}, 2'b00);
        chk("rst_ack", {stop_ack, ack4}, 2'b00);
        chk("rst_active", {active, act4}, 2'b00);
        chk("rst_busy", {busy, busy4}, 2'b00);
        chk("rst_count", {strobe_count, cnt4}, 20'd0);
        model_reset();
        @(negedge clk);
        clear_tallies();
        step();
        rst_n = 1'b1;
        step();
        enable = 1'b0;
        step();
        chk("req036_no_ack_after_reset", n_ack, 0);

        // Randomized traffic, including changes to interval/delay while running.
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 24) == 0) enable = ~enable;
            stop_req    = !stop_req && ($urandom_range(0, 15) == 0);
            user_marker = 1'($urandom_range(0, 1));
            interval    = 16'($urandom_range(0, 3));
            delay_value = 16'($urandom_range(0, 4));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
